// File: rtl/device_eth_gen.sv
// device_eth_gen: test-only Ethernet RX frame-train generator driving the 64-bit eth_rx_* stream.
// Define DEVICE_ETH_GEN_ERR_EN to flag every ERR_PERIOD-th frame with tuser on its tlast beat.
module device_eth_gen #(
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned LEN_MIN    = 64,
  parameter int unsigned LEN_MAX    = 64,
  parameter int unsigned GAP_CYCLES = 12,
  parameter logic [47:0] DST_MAC    = 48'h90e2ba5d8dc9,
  parameter logic [47:0] SRC_MAC    = 48'h001122334455,
  parameter logic [15:0] ETHERTYPE  = 16'h0800,
  parameter int unsigned ERR_PERIOD = 3
) (
  input  logic        eth_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        eth_rx_tready,
  output logic        eth_rx_tvalid,
  output logic [63:0] eth_rx_tdata,
  output logic [7:0]  eth_rx_tkeep,
  output logic        eth_rx_tlast,
  output logic        eth_rx_tuser,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt
);

  localparam logic [13:0] L_MIN    = 14'(LEN_MIN);
  localparam logic [13:0] L_RANGE  = 14'(LEN_MAX - LEN_MIN + 1);
  localparam logic [15:0] N_FRAMES = 16'(NUM_FRAMES);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  if (LEN_MIN < 16 || LEN_MAX > 9000 || LEN_MIN > LEN_MAX || GAP_CYCLES > 255 ||
      ERR_PERIOD < 1 || ERR_PERIOD > 255) begin : g_bad_params
    $error("device_eth_gen: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  function automatic logic [7:0] frame_byte(input logic [15:0] n, input logic [13:0] i);
    logic [111:0] hdr;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE};
    if (i < 14'd14)       return hdr[8*(13 - int'(i)) +: 8];
    else if (i == 14'd14) return n[15:8];
    else if (i == 14'd15) return n[7:0];
    else                  return i[7:0] + n[7:0];
  endfunction

  // Beat starting at byte offset off of a len-byte frame; unused lanes stay zero.
  function automatic beat_t make_beat(input logic [15:0] n, input logic [13:0] len,
                                      input logic [13:0] off);
    beat_t       b;
    logic [13:0] i;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      i = off + 14'(k);
      if (i < len) begin
        b.keep[k]        = 1'b1;
        b.data[8*k +: 8] = frame_byte(n, i);
      end
    end
    b.last = (off + 14'd8 >= len);
    return b;
  endfunction

  state_t      state, state_d;
  logic [15:0] cnt_d, cnt_inc;
  logic [13:0] idx, idx_d, idx_inc, off, off_d, len;
  logic [7:0]  gap, gap_d;
  logic        done_d, busy_d, valid_d, last_d, user_d;
  logic [63:0] data_d;
  logic [7:0]  keep_d;
  logic        hs, load, clear, nb_err;
  beat_t       nb;
  logic        err_first, err_cur, err_nxt;

  assign hs      = eth_rx_tvalid & eth_rx_tready;
  assign cnt_inc = frame_cnt + 16'd1;
  assign idx_inc = (idx == L_RANGE - 14'd1) ? 14'd0 : idx + 14'd1;
  assign len     = L_MIN + idx;

`ifdef DEVICE_ETH_GEN_ERR_EN
  // err_ph tracks n mod ERR_PERIOD for the frame currently being sent.
  localparam logic [7:0] ERR_LAST = 8'(ERR_PERIOD - 1);
  logic [7:0] err_ph, err_ph_inc;
  assign err_ph_inc = (err_ph == ERR_LAST) ? 8'd0 : err_ph + 8'd1;
  assign err_first  = (ERR_LAST == 8'd0);
  assign err_cur    = (err_ph == ERR_LAST);
  assign err_nxt    = (err_ph_inc == ERR_LAST);

  always_ff @(posedge eth_clk) begin
    if (sys_rst)                                       err_ph <= 8'd0;
    else if ((state == IDLE || state == DONE) && start) err_ph <= 8'd0;
    else if (state == SEND && hs && eth_rx_tlast)       err_ph <= err_ph_inc;
  end
`else
  assign err_first = 1'b0;
  assign err_cur   = 1'b0;
  assign err_nxt   = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = frame_cnt;
    idx_d   = idx;
    off_d   = off;
    gap_d   = gap;
    done_d  = done;
    valid_d = eth_rx_tvalid;
    data_d  = eth_rx_tdata;
    keep_d  = eth_rx_tkeep;
    last_d  = eth_rx_tlast;
    user_d  = eth_rx_tuser;
    nb      = '0;
    nb_err  = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = SEND;
          cnt_d   = '0;
          idx_d   = '0;
          off_d   = '0;
          done_d  = 1'b0;
          nb      = make_beat(16'd0, L_MIN, 14'd0);
          nb_err  = err_first;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (hs && !eth_rx_tlast) begin
          off_d  = off + 14'd8;
          nb     = make_beat(frame_cnt, len, off + 14'd8);
          nb_err = err_cur;
          load   = 1'b1;
        end else if (hs) begin
          cnt_d = cnt_inc;
          idx_d = idx_inc;
          off_d = '0;
          if (N_FRAMES != 16'd0 && cnt_inc == N_FRAMES) begin
            state_d = DONE;
            done_d  = 1'b1;
            clear   = 1'b1;
          end else if (GAP_CYCLES != 0) begin
            state_d = GAP;
            gap_d   = '0;
            clear   = 1'b1;
          end else begin
            nb     = make_beat(cnt_inc, L_MIN + idx_inc, 14'd0);
            nb_err = err_nxt;
            load   = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap == GAP_LAST) begin
          state_d = SEND;
          nb      = make_beat(frame_cnt, len, 14'd0);
          nb_err  = err_cur;
          load    = 1'b1;
        end else begin
          gap_d = gap + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      valid_d = 1'b1;
      data_d  = nb.data;
      keep_d  = nb.keep;
      last_d  = nb.last;
      user_d  = nb.last & nb_err;
    end else if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
      keep_d  = '0;
      last_d  = 1'b0;
      user_d  = 1'b0;
    end
    busy_d = (state_d == SEND) || (state_d == GAP);
  end

  always_ff @(posedge eth_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      idx           <= '0;
      off           <= '0;
      gap           <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      eth_rx_tvalid <= 1'b0;
      eth_rx_tdata  <= '0;
      eth_rx_tkeep  <= '0;
      eth_rx_tlast  <= 1'b0;
      eth_rx_tuser  <= 1'b0;
    end else begin
      state         <= state_d;
      frame_cnt     <= cnt_d;
      idx           <= idx_d;
      off           <= off_d;
      gap           <= gap_d;
      done          <= done_d;
      busy          <= busy_d;
      eth_rx_tvalid <= valid_d;
      eth_rx_tdata  <= data_d;
      eth_rx_tkeep  <= keep_d;
      eth_rx_tlast  <= last_d;
      eth_rx_tuser  <= user_d;
    end
  end

endmodule
